// File: rtl/escalonador_conversor_bcd_pkg.sv
// -----------------------------------------------------------------------------
// escalonador_conversor_bcd_pkg
// Shared definitions for the BCD converter scheduler:
//   - estado_t       : FSM state encoding (OCIOSO, CONVERTE, RESPONDE)
//   - LIMITE_BCD     : largest operand that fits in two BCD digits
//   - DIGITO_APAGADO : digit code that blanks a 7-segment display
//   - DIGITO_SATURADO: digit used when out-of-range values saturate to 99
//                      (only used when SATURA_99_EN is defined)
// -----------------------------------------------------------------------------
package escalonador_conversor_bcd_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        RESPONDE = 2'd2
    } estado_t;

    localparam logic [7:0] LIMITE_BCD      = 8'd99;
    localparam logic [3:0] DIGITO_APAGADO  = 4'hF;
    localparam logic [3:0] DIGITO_SATURADO = 4'd9;

endpackage

// File: rtl/escalonador_conversor_bcd_if.sv
// -----------------------------------------------------------------------------
// escalonador_conversor_bcd_if
// Bundles the request side, the shared converter link and the response side.
//
// Handshake rules (both sides): a transfer happens in a cycle where valid and
// ready are both 1. A requester holds req_valid and its operand until it sees
// its req_ready bit; req_ready is a one-cycle, one-hot accept pulse. The
// response side holds resp_valid and its payload stable until resp_ready.
//
// Modports:
//   slave  : the scheduler (drives req_ready, conv_binario, resp_*, estado)
//   master : the environment (requesters, converter and consumer)
// estado is a debug view of the scheduler FSM.
// -----------------------------------------------------------------------------
interface escalonador_conversor_bcd_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    import escalonador_conversor_bcd_pkg::*;

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_binario;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         conv_binario;
    logic [3:0]         conv_dezenas;
    logic [3:0]         conv_unidades;
    logic               resp_valid;
    logic               resp_ready;
    logic [ID_W-1:0]    resp_id;
    logic [3:0]         resp_dezenas;
    logic [3:0]         resp_unidades;
    logic               resp_erro;
    estado_t            estado;

    modport slave (
        input  req_valid, req_binario, conv_dezenas, conv_unidades, resp_ready,
        output req_ready, conv_binario, resp_valid, resp_id, resp_dezenas,
               resp_unidades, resp_erro, estado
    );

    modport master (
        output req_valid, req_binario, conv_dezenas, conv_unidades, resp_ready,
        input  req_ready, conv_binario, resp_valid, resp_id, resp_dezenas,
               resp_unidades, resp_erro, estado
    );

endinterface

// File: rtl/escalonador_conversor_bcd_arbitro_round_robin.sv
// -----------------------------------------------------------------------------
// arbitro_round_robin
// Combinational round-robin pick: the first set bit of req_valid searching
// from ponteiro upward, wrapping to 0.
// Ports:
//   req_valid [N_REQ] : pending requests
//   ponteiro  [ID_W]  : index with the highest priority this cycle
//   grant     [N_REQ] : one-hot winner (all zero when nothing is pending)
//   g         [ID_W]  : binary index of the winner (0 when nothing is pending)
// -----------------------------------------------------------------------------
module arbitro_round_robin #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  ponteiro,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  g
);

    logic achou;
    int   idx;

    always_comb begin
        grant = '0;
        g     = '0;
        achou = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            // ponteiro is always < N_REQ, so a single subtraction wraps it
            idx = int'(ponteiro) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!achou && req_valid[idx]) begin
                achou      = 1'b1;
                grant[idx] = 1'b1;
                g          = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/escalonador_conversor_bcd.sv
// -----------------------------------------------------------------------------
// escalonador_conversor_bcd
// Shares one external combinational binary-to-BCD converter among N_REQ
// requesters. One transaction at a time: grant (OCIOSO), hold the registered
// operand for ESPERA cycles (CONVERTE), then present the result until the
// consumer accepts it (RESPONDE).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : escalonador_conversor_bcd_if.slave (requests, converter link,
//           response, FSM debug state)
// Parameters: N_REQ (2..8), ESPERA (1..15), ID_W (>= clog2(N_REQ)).
// Build option: SATURA_99_EN -- when defined, out-of-range operands report 9/9
// instead of the blanking code F/F (resp_erro is 1 in both cases).
// -----------------------------------------------------------------------------
module escalonador_conversor_bcd
    import escalonador_conversor_bcd_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ESPERA = 1,
    parameter int ID_W   = 2
) (
    input logic                          clk,
    input logic                          reset,
    escalonador_conversor_bcd_if.slave   bus
);

    estado_t          estado, estado_prox;
    logic [ID_W-1:0]  ponteiro;
    logic [3:0]       contador;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  g;
    logic [N_REQ-1:0] req_ready_c;
    logic [7:0]       operando;
    logic             ultimo_ciclo;

    logic [7:0]       conv_reg;
    logic [ID_W-1:0]  id_reg;
    logic [3:0]       dez_reg;
    logic [3:0]       uni_reg;
    logic             erro_reg;

    arbitro_round_robin #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arbitro (
        .req_valid (bus.req_valid),
        .ponteiro  (ponteiro),
        .grant     (grant),
        .g         (g)
    );

    // Operand of the winning requester
    always_comb begin
        operando = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                operando = bus.req_binario[8*i +: 8];
            end
        end
    end

    assign ultimo_ciclo = (contador == 4'(ESPERA - 1));

    always_comb begin
        estado_prox = estado;
        req_ready_c = '0;
        case (estado)
            OCIOSO: begin
                if (|bus.req_valid) begin
                    req_ready_c = grant;
                    estado_prox = CONVERTE;
                end
            end
            CONVERTE: begin
                if (ultimo_ciclo) begin
                    estado_prox = RESPONDE;
                end
            end
            RESPONDE: begin
                if (bus.resp_ready) begin
                    estado_prox = OCIOSO;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado   <= OCIOSO;
            ponteiro <= '0;
            contador <= '0;
            conv_reg <= '0;
            id_reg   <= '0;
            dez_reg  <= '0;
            uni_reg  <= '0;
            erro_reg <= 1'b0;
        end else begin
            estado <= estado_prox;
            case (estado)
                OCIOSO: begin
                    if (|bus.req_valid) begin
                        conv_reg <= operando;
                        id_reg   <= g;
                        // The winner gets the lowest priority next time
                        ponteiro <= (g == ID_W'(N_REQ - 1)) ? '0 : g + 1'b1;
                        contador <= '0;
                    end
                end
                CONVERTE: begin
                    contador <= contador + 4'd1;
                    if (ultimo_ciclo) begin
                        if (conv_reg > LIMITE_BCD) begin
                            erro_reg <= 1'b1;
`ifdef SATURA_99_EN
                            dez_reg  <= DIGITO_SATURADO;
                            uni_reg  <= DIGITO_SATURADO;
`else
                            dez_reg  <= DIGITO_APAGADO;
                            uni_reg  <= DIGITO_APAGADO;
`endif
                        end else begin
                            erro_reg <= 1'b0;
                            dez_reg  <= bus.conv_dezenas;
                            uni_reg  <= bus.conv_unidades;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // A grant while reset is high would be lost, so it is suppressed
    assign bus.req_ready     = reset ? '0 : req_ready_c;
    assign bus.conv_binario  = conv_reg;
    assign bus.resp_valid    = (estado == RESPONDE);
    assign bus.resp_id       = id_reg;
    assign bus.resp_dezenas  = dez_reg;
    assign bus.resp_unidades = uni_reg;
    assign bus.resp_erro     = erro_reg;
    assign bus.estado        = estado;

endmodule

// File: tb/tb_escalonador_conversor_bcd.sv
// -----------------------------------------------------------------------------
// tb_escalonador_conversor_bcd
// Self-checking bench for escalonador_conversor_bcd. A transaction-level model
// predicts grants (round-robin over pending requests), response latency,
// operand hold and the response payload computed with plain arithmetic.
// Honours SATURA_99_EN for the out-of-range expectation.
// -----------------------------------------------------------------------------
module tb_escalonador_conversor_bcd;
    import escalonador_conversor_bcd_pkg::*;

    localparam int N_REQ  = 4;
    localparam int ESPERA = 1;
    localparam int ID_W   = 2;
    localparam int RW     = ID_W + 9;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    escalonador_conversor_bcd_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    escalonador_conversor_bcd #(
        .N_REQ  (N_REQ),
        .ESPERA (ESPERA),
        .ID_W   (ID_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // External converter: plain decimal digits of the operand
    always_comb begin
        bus.conv_dezenas  = 4'((int'(bus.conv_binario) / 10) % 10);
        bus.conv_unidades = 4'(int'(bus.conv_binario) % 10);
    end

    // ---------------- stimulus state ----------------
    logic [N_REQ-1:0] pend;
    logic [7:0]       op [N_REQ];
    logic             rr_v;
    logic             rst_v;

    // ---------------- model / scoreboard ----------------
    logic [RW-1:0] exp_q[$];
    int            n_vetores;
    int            n_erros;
    int            ciclo_n;
    int            t_grant;
    int            ptr_m;
    bit            ocupado;
    bit            apos_reset;
    bit            houve_grant;
    logic [7:0]    op_atual;

    task automatic checar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vetores++;
        if (obs !== exp) begin
            n_erros++;
            $display("FAIL %s: obtido=%0h esperado=%0h (ciclo %0d)", tag, obs, exp, ciclo_n);
        end
    endtask

    function automatic logic [RW-1:0] esperado(input int id, input int v);
        logic [3:0] d, u;
        logic       e;
        if (v > 99) begin
            e = 1'b1;
`ifdef SATURA_99_EN
            d = 4'd9;
            u = 4'd9;
`else
            d = 4'hF;
            u = 4'hF;
`endif
        end else begin
            e = 1'b0;
            d = 4'(v / 10);
            u = 4'(v % 10);
        end
        return {ID_W'(id), d, u, e};
    endfunction

    function automatic logic [7:0] sorteia_op();
        int limites [4] = '{0, 99, 100, 255};
        case ($urandom_range(0, 7))
            0:       return 8'(limites[$urandom_range(0, 3)]);
            1:       return 8'($urandom_range(100, 255));
            default: return 8'($urandom_range(0, 99));
        endcase
    endfunction

    // ---------------- driver: one cycle ----------------
    task automatic ciclo();
        logic [N_REQ-1:0] exp_gnt;
        logic [RW-1:0]    obs_resp;
        int               g;
        int               idx;
        bit               exp_valid;

        @(negedge clk);
        reset           = rst_v;
        bus.req_valid   = pend;
        for (int i = 0; i < N_REQ; i++) bus.req_binario[8*i +: 8] = op[i];
        bus.resp_ready  = rr_v;
        #1;
        ciclo_n++;
        houve_grant = 1'b0;

        if (apos_reset) begin
            checar("rst_conv_binario", 32'(bus.conv_binario), 0);
            checar("rst_resp_valid", 32'(bus.resp_valid), 0);
            checar("rst_resp_id", 32'(bus.resp_id), 0);
            checar("rst_resp_dezenas", 32'(bus.resp_dezenas), 0);
            checar("rst_resp_unidades", 32'(bus.resp_unidades), 0);
            checar("rst_resp_erro", 32'(bus.resp_erro), 0);
        end

        exp_gnt = '0;
        g = -1;
        if (!rst_v && !ocupado) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (ptr_m + k) % N_REQ;
                if (g < 0 && pend[idx]) g = idx;
            end
        end
        if (g >= 0) exp_gnt[g] = 1'b1;
        checar("req_ready", 32'(bus.req_ready), 32'(exp_gnt));

        exp_valid = ocupado && (ciclo_n >= t_grant + 1 + ESPERA);
        checar("resp_valid", 32'(bus.resp_valid), 32'(exp_valid));

        if (exp_valid && bus.resp_valid) begin
            if (exp_q.size() == 0) begin
                checar("fila_resposta", 32'(exp_q.size()), 1);
            end else begin
                obs_resp = {bus.resp_id, bus.resp_dezenas, bus.resp_unidades, bus.resp_erro};
                checar("resposta", 32'(obs_resp), 32'(exp_q[0]));
            end
        end

        if (ocupado && ciclo_n > t_grant && ciclo_n <= t_grant + ESPERA) begin
            checar("conv_binario", 32'(bus.conv_binario), 32'(op_atual));
        end

        // Model update for the coming rising edge
        if (rst_v) begin
            ocupado    = 1'b0;
            ptr_m      = 0;
            exp_q.delete();
            apos_reset = 1'b1;
        end else begin
            apos_reset = 1'b0;
            if (exp_valid && rr_v) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                ocupado = 1'b0;
            end else if (g >= 0) begin
                ocupado     = 1'b1;
                t_grant     = ciclo_n;
                op_atual    = op[g];
                exp_q.push_back(esperado(g, int'(op[g])));
                ptr_m       = (g + 1) % N_REQ;
                pend[g]     = 1'b0;
                houve_grant = 1'b1;
            end
        end
    endtask

    task automatic sortear();
        for (int i = 0; i < N_REQ; i++) begin
            if (!pend[i]) begin
                if ($urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    op[i]   = sorteia_op();
                end
            end else if ($urandom_range(0, 19) == 0) begin
                pend[i] = 1'b0;
            end
        end
        rr_v = ($urandom_range(0, 3) != 0);
    endtask

    task automatic espera_grant(input string tag);
        houve_grant = 1'b0;
        for (int k = 0; k < 20 && !houve_grant; k++) ciclo();
        checar(tag, 32'(houve_grant), 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int valores [4] = '{99, 100, 255, 0};

        pend = '0;
        for (int i = 0; i < N_REQ; i++) op[i] = '0;
        rr_v = 1'b0;
        rst_v = 1'b1;
        n_vetores = 0;
        n_erros = 0;
        ciclo_n = 0;
        t_grant = 0;
        ptr_m = 0;
        ocupado = 1'b0;
        apos_reset = 1'b0;
        houve_grant = 1'b0;
        op_atual = '0;
        bus.req_valid = '0;
        bus.req_binario = '0;
        bus.resp_ready = 1'b0;

        // Reset: outputs cleared
        repeat (3) ciclo();
        rst_v = 1'b0;

        // Single request: 42 -> 4,2 from requester 0
        pend[0] = 1'b1;
        op[0] = 8'd42;
        rr_v = 1'b1;
        repeat (5) ciclo();

        // Round robin with all four requesters continuously valid
        op[0] = 8'd10; op[1] = 8'd21; op[2] = 8'd32; op[3] = 8'd43;
        repeat (16) begin
            pend = '1;
            ciclo();
        end
        pend = '0;
        repeat (4) ciclo();

        // Backpressure: response held while the consumer stalls
        pend[0] = 1'b1;
        op[0] = 8'd57;
        rr_v = 1'b0;
        espera_grant("grant_backpressure");
        pend[1] = 1'b1; op[1] = 8'd61;
        pend[2] = 1'b1; op[2] = 8'd120;
        pend[3] = 1'b1; op[3] = 8'd3;
        repeat (ESPERA + 6) ciclo();
        rr_v = 1'b1;
        repeat (12) ciclo();
        pend = '0;
        repeat (4) ciclo();

        // Range boundaries
        foreach (valores[i]) begin
            pend[1] = 1'b1;
            op[1] = 8'(valores[i]);
            espera_grant("grant_faixa");
            repeat (ESPERA + 2) ciclo();
        end

        // Reset in the middle of a conversion
        pend = 4'b0110;
        op[1] = 8'd33;
        op[2] = 8'd77;
        espera_grant("grant_antes_reset");
        rst_v = 1'b1;
        ciclo();
        rst_v = 1'b0;
        pend[0] = 1'b1;
        op[0] = 8'd5;
        repeat (12) ciclo();

        // Randomized traffic
        repeat (3000) begin
            sortear();
            ciclo();
        end

        // Drain
        pend = '0;
        rr_v = 1'b1;
        repeat (20) ciclo();
        checar("fila_final", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vetores, n_erros);
        $finish;
    end

endmodule

// File: doc/escalonador_conversor_bcd.md
Name: escalonador_conversor_bcd

Overview:
- Shares one combinational binary-to-BCD converter (8-bit in, two 4-bit BCD digits out) among N_REQ requesters, e.g. counters and display sources.
- Round-robin arbiter, valid/ready handshake on request and response sides, registered converter input, range check for values above 99.
- Sits between the data sources and the 7-segment display drivers.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ESPERA, 1, settle cycles the converter input is held before results are sampled (1..15).
- ID_W, 2, width of requester id; must be >= clog2(N_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  request pending, one bit per requester; held until matching req_ready.
- req_binario  in  8*N_REQ  operand per requester; slice i = [8*i+7:8*i].
- req_ready  out  N_REQ  one-hot, one-cycle grant/accept pulse.
- conv_binario  out  8  registered operand to the shared converter.
- conv_dezenas  in  4  converter tens digit.
- conv_unidades  in  4  converter units digit.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  ID_W  requester that owns the result.
- resp_dezenas  out  4  BCD tens.
- resp_unidades  out  4  BCD units.
- resp_erro  out  1  operand was greater than 99.

Behaviour:
- Reset (sync, high): state OCIOSO, pointer=0, wait counter=0. All outputs go to 0: req_ready, conv_binario, resp_valid, resp_id, resp_dezenas, resp_unidades, resp_erro.
- FSM has 3 states: OCIOSO, CONVERTE, RESPONDE.
- OCIOSO:
  - If any req_valid is set, pick the first set bit searching from pointer upward, wrapping to 0.
  - req_ready[g]=1 in that cycle. req_ready is combinational from state and req_valid and is 0 in every other state.
  - Next edge: conv_binario <= slice g, resp_id <= g, pointer <= (g+1) mod N_REQ, counter <= 0, go to CONVERTE.
  - If no req_valid is set, stay; pointer holds.
- CONVERTE:
  - conv_binario is held stable and the counter increments.
  - When counter == ESPERA-1: sample conv_dezenas/conv_unidades into resp_dezenas/resp_unidades, set resp_erro = (conv_binario > 99), go to RESPONDE.
  - resp_valid is asserted from the next cycle.
- Out-of-range operand (resp_erro=1): resp_dezenas = resp_unidades = 4'hF, which blanks the display.
- RESPONDE:
  - resp_valid=1. resp_id, resp_dezenas, resp_unidades and resp_erro are stable while resp_valid && !resp_ready.
  - On resp_valid && resp_ready: next edge resp_valid=0, go to OCIOSO. No grant happens in the same cycle.
- Latency: grant at cycle T gives resp_valid at T+1+ESPERA. Minimum issue interval is ESPERA+2 cycles.
- Only one transaction is in flight at a time, and no new grant is made while the response is unaccepted.
- Requesters:
  - Dropping req_valid after the grant has no effect, because the operand is already captured.
  - Dropping req_valid before the grant withdraws the request.
  - Requester g keeps the lowest priority on the next arbitration, which gives fairness.
- Pointer wrap: after granting N_REQ-1, pointer=0.
- Reset mid-transaction: the transaction is aborted with no response, and pointer returns to 0. A requester that was not yet granted still holds req_valid and is re-arbitrated after reset.
- Boundary values: 0 -> 0,0, erro=0. 99 -> 9,9, erro=0. 100 -> F,F, erro=1. 255 -> F,F, erro=1.

Optional Feature:
- Macro SATURA_99_EN.
- Defined: an out-of-range operand returns resp_dezenas=9, resp_unidades=9, resp_erro=1.
- Undefined: the default 4'hF/4'hF blanking described above.

Decomposition:
- Shared package: state encodings (OCIOSO=2'd0, CONVERTE=2'd1, RESPONDE=2'd2), LIMITE_BCD=8'd99, DIGITO_APAGADO=4'hF.
- Sub-module arbitro_round_robin: combinational; inputs req_valid and pointer; outputs one-hot grant and binary index g.
- The FSM, counter and response registers stay in the top module.

Test Plan:
- Single request: reset, then req_valid=0001 with slice0=8'd42, resp_ready=1 (ESPERA=1). Expect req_ready=0001 at T, resp_valid at T+2 with id=0, dezenas=4, unidades=2, erro=0.
- Round-robin: all four requesters valid continuously with operands 10, 21, 32, 43 and resp_ready=1. Grant order 0,1,2,3,0 with matching digits; pointer wraps 3->0.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid. Outputs stay stable, no req_ready pulses, and after resp_ready=1 the next grant comes 1 cycle after acceptance.
- Range: operands 99, 100 and 255. Expect 9,9 erro=0; F,F erro=1; F,F erro=1. With SATURA_99_EN, expect 9,9 erro=1 for both out-of-range cases.
- Reset mid-op: reset asserted in CONVERTE. Next cycle resp_valid=0 and conv_binario=0, pointer restarts at 0, and a still-pending requester 2 is granted afterwards.
- ESPERA=3: verify conv_binario is held 3 cycles and resp_valid appears at T+4.
